// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Division by zero and signed overflow bypass the iteration and complete one edge after accept.
module div_unit #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        op_i,
  input  logic [DWIDTH-1:0] op1_i,
  input  logic [DWIDTH-1:0] op2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DWIDTH-1:0] res_o
);

  localparam int unsigned CW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0] rem_q, rem_d;
  logic [DWIDTH-1:0] quo_q, quo_d;
  logic [DWIDTH-1:0] dvs_q, dvs_d;
  logic [DWIDTH-1:0] res_q, res_d;
  logic              sel_rem_q, sel_rem_d;
  logic              neg_quo_q, neg_quo_d;
  logic              neg_rem_q, neg_rem_d;

  logic [DWIDTH:0]   shifted;
  logic [DWIDTH:0]   diff;
  logic [DWIDTH-1:0] rem_nxt;
  logic [DWIDTH-1:0] quo_nxt;
  logic              a_neg;
  logic              b_neg;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    sel_rem_d = sel_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;

    // quo_q doubles as the dividend shift register: its MSB feeds the partial remainder
    shifted = {rem_q, quo_q[DWIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    rem_nxt = diff[DWIDTH] ? shifted[DWIDTH-1:0] : diff[DWIDTH-1:0];
    quo_nxt = {quo_q[DWIDTH-2:0], ~diff[DWIDTH]};

    a_neg = ~op_i[0] & op1_i[DWIDTH-1];
    b_neg = ~op_i[0] & op2_i[DWIDTH-1];

    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          sel_rem_d = op_i[1];
          if (op2_i == '0) begin
            res_d   = op_i[1] ? op1_i : '1;
            state_d = DONE;
          end else if (!op_i[0] && (op1_i == MOST_NEG) && (op2_i == '1)) begin
            res_d   = op_i[1] ? '0 : op1_i;
            state_d = DONE;
          end else begin
            quo_d     = a_neg ? -op1_i : op1_i;
            dvs_d     = b_neg ? -op2_i : op2_i;
            rem_d     = '0;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            cnt_d     = CW'(DWIDTH - 1);
            state_d   = ITER;
          end
        end
      end
      ITER: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (cnt_q == '0) begin
          // sign correction is folded into the final iteration so DONE needs no extra cycle
          if (sel_rem_q) res_d = neg_rem_q ? -rem_nxt : rem_nxt;
          else           res_d = neg_quo_q ? -quo_nxt : quo_nxt;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      sel_rem_q <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_q     <= res_d;
      sel_rem_q <= sel_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = valid_o ? res_q : '0;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: expected results queued at accept, compared when valid_o rises.
module tb_div_unit;

  localparam int unsigned DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i, flush_i, valid_i, ready_i;
  logic          ready_o, valid_o;
  logic [1:0]    op_i;
  logic [DW-1:0] op1_i, op2_i, res_o;

  int unsigned   checks = 0;
  int unsigned   errors = 0;
  logic [DW-1:0] sb[$];

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  div_unit #(.DWIDTH(DW)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic signed [DW-1:0] sa, sb_;
    sa  = a;
    sb_ = b;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? '0 : a;
    case (op)
      OP_DIV:  return sa / sb_;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb_;
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [DW-1:0] a,
                                    input logic [DW-1:0] b);
    return (b == '0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Accept one request and push its expected result; returns after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int unsigned n = 0;
    while (ready_o !== 1'b1 && n < 100) begin step(); n++; end
    op_i = op; op1_i = a; op2_i = b; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    sb.push_back(model(op, a, b));
  endtask

  // Waits for valid_o, checks latency (edges after accept) and pops the scoreboard.
  task automatic collect(input string tag, input int unsigned exp_edges);
    int unsigned edges = 0;
    logic [DW-1:0] exp;
    while (valid_o !== 1'b1 && edges < 200) begin step(); edges++; end
    chk({tag, "_lat"}, DW'(edges), DW'(exp_edges));
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    chk({tag, "_res"}, res_o, exp);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [DW-1:0] a,
                        input logic [DW-1:0] b);
    ready_i = 1'b1;
    issue(op, a, b);
    // special results appear in the cycle right after the accept edge
    collect(tag, is_special(op, a, b) ? 0 : DW);
    step();
    chk({tag, "_idle"}, DW'(ready_o), 1);
  endtask

  initial begin
    logic [DW-1:0] held, ra, rb;
    bit            seen;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    op_i = '0; op1_i = '0; op2_i = '0;
    step(); step();
    rst_i = 1'b0;
    chk("rst_ready", DW'(ready_o), 1);
    chk("rst_valid", DW'(valid_o), 0);
    chk("rst_res", res_o, 0);

    run_op("divu_100_7", OP_DIVU, 100, 7);
    run_op("remu_100_7", OP_REMU, 100, 7);
    run_op("div_m7_2", OP_DIV, -32'sd7, 2);
    run_op("rem_m7_2", OP_REM, -32'sd7, 2);
    run_op("rem_7_m2", OP_REM, 7, -32'sd2);
    run_op("divu_5_0", OP_DIVU, 5, 0);
    run_op("rem_5_0", OP_REM, 5, 0);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("divu_max", OP_DIVU, 32'hFFFF_FFFF, 1);
    run_op("div_neg_neg", OP_DIV, 32'h8000_0000, -32'sd3);

    // Inputs changed during ITER must not disturb the result
    ready_i = 1'b1;
    issue(OP_DIVU, 1000, 10);
    op_i = OP_REM; op1_i = 32'h1234_5678; op2_i = 3; valid_i = 1'b1;
    step(); step();
    valid_i = 1'b0;
    collect("iter_ignore", DW - 2);
    step();

    for (int unsigned i = 0; i < 8; i++) begin
      ra = $urandom();
      rb = (i % 2 == 0) ? $urandom_range(1, 1000) : $urandom();
      run_op("rand", 2'(i % 4), ra, rb);
    end

    // Backpressure: result held for 10 cycles with ready_i low
    ready_i = 1'b0;
    issue(OP_DIVU, 500, 7);
    collect("bp", DW);
    held = res_o;
    seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      if (res_o !== held || ready_o !== 1'b0 || valid_o !== 1'b1) seen = 1'b1;
    end
    chk("bp_stable", DW'(seen), 0);
    ready_i = 1'b1;
    step();
    chk("bp_release", DW'(ready_o), 1);
    chk("bp_release_valid", DW'(valid_o), 0);

    // Abort in cycle 10 of ITER with a concurrent new request
    op_i = OP_DIVU; op1_i = 1000; op2_i = 3; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (9) step();
    flush_i = 1'b1; valid_i = 1'b1; op_i = OP_DIVU; op1_i = 50; op2_i = 5;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_idle", DW'(ready_o), 1);
    seen = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0 || ready_o !== 1'b1) seen = 1'b1;
      step();
    end
    chk("flush_no_result", DW'(seen), 0);
    run_op("after_flush", OP_DIVU, 9, 3);

    // Reset mid-ITER
    op_i = OP_DIVU; op1_i = 77; op2_i = 7; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    repeat (5) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_iter_ready", DW'(ready_o), 1);
    chk("rst_iter_valid", DW'(valid_o), 0);
    chk("rst_iter_res", res_o, 0);
    seen = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      if (valid_o !== 1'b0) seen = 1'b1;
      step();
    end
    chk("rst_iter_stale", DW'(seen), 0);

    // Reset while holding a result in DONE
    ready_i = 1'b0;
    op_i = OP_REMU; op1_i = 5; op2_i = 0; valid_i = 1'b1;
    step();
    valid_i = 1'b0;
    chk("rst_done_pre", DW'(valid_o), 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rst_done_ready", DW'(ready_o), 1);
    chk("rst_done_valid", DW'(valid_o), 0);
    chk("rst_done_res", res_o, 0);
    run_op("after_rst", OP_DIV, -32'sd100, 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
